// File: rtl/johnson_seq_counter.sv
// -----------------------------------------------------------------------------
// johnson_seq_counter
//   Johnson-code sequence counter with 2*WIDTH states. It supports up/down
//   counting, a count enable, a parallel load by state index and a
//   synchronous reset. A load with an out-of-range index raises an error flag.
//   The cout output pulses on every wrap, so the cout of one stage can drive
//   the en input of the next stage in a chain of divide-by-2*WIDTH counters.
//
// Parameters
//   WIDTH     code width in bits, must be >= 2; the sequence has N = 2*WIDTH states
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        count enable
//   up        1 = step toward higher index, 0 = step toward lower index
//   load      parallel load request; takes priority over en
//   load_idx  state index to load, valid range 0..N-1
//   q         current Johnson code, registered; always equals code(idx)
//   idx       current state index, registered
//   cout      one-cycle pulse after a wrap (N-1 -> 0 going up, 0 -> N-1 going down)
//   err       one-cycle pulse after a load with load_idx >= N
// -----------------------------------------------------------------------------
module johnson_seq_counter #(
    parameter int WIDTH = 3,
    localparam int IW   = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [IW-1:0]    load_idx,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             cout,
    output logic             err
);

    localparam int unsigned N    = 2 * WIDTH;
    localparam int unsigned W    = WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Johnson code for state index k:
    //   - for k < WIDTH, the lower k bits are set;
    //   - otherwise, the ones are shifted left by (k - WIDTH).
    function automatic logic [WIDTH-1:0] code_of(input logic [IW-1:0] k);
        logic [WIDTH-1:0] ones;
        int unsigned      ki;
        ones = '1;
        ki   = 32'(k);
        if (ki < W) code_of = ~(ones << ki);
        else        code_of = ones << (ki - W);
    endfunction

    logic [IW-1:0] idx_nxt;
    logic          cout_nxt;
    logic          err_nxt;

    // Priority on each edge is load > en > hold. Reset is applied in the register.
    always_comb begin
        // NOTE: default every output of the block first, so no path can leave
        // an output unassigned and infer a latch.
        idx_nxt  = idx;
        cout_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (load) begin
            if (32'(load_idx) < N) idx_nxt = load_idx;
            else                   err_nxt = 1'b1;
        end else if (en) begin
            if (up) begin
                if (idx == LAST) begin
                    idx_nxt  = '0;
                    cout_nxt = 1'b1;
                end else begin
                    idx_nxt  = idx + 1'b1;
                end
            end else begin
                if (idx == '0) begin
                    idx_nxt  = LAST;
                    cout_nxt = 1'b1;
                end else begin
                    idx_nxt  = idx - 1'b1;
                end
            end
        end
    end

    // q is registered from the next index rather than decoded from idx, so both
    // outputs leave flops and always change on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for state, so every flop samples
        // values from before the edge, regardless of statement order.
        if (reset) begin
            idx  <= '0;
            q    <= '0;
            cout <= 1'b0;
            err  <= 1'b0;
        end else begin
            idx  <= idx_nxt;
            q    <= code_of(idx_nxt);
            cout <= cout_nxt;
            err  <= err_nxt;
        end
    end

endmodule
